// File: rtl/dispatch_credit_ctrl_pkg.sv
// dispatch_credit_ctrl_pkg: reservation-station class encoding and the opcode
// grouping used to pick a class at dispatch.
package dispatch_credit_ctrl_pkg;

    typedef enum logic [1:0] {
        DC_ALU  = 2'd0,
        DC_LS   = 2'd1,
        DC_BR   = 2'd2,
        DC_NONE = 2'd3
    } dc_class_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    function automatic dc_class_e op_to_class(input logic [6:0] opcode);
        case (opcode)
            OPC_OP_IMM, OPC_OP, OPC_LUI, OPC_AUIPC, OPC_SYSTEM: op_to_class = DC_ALU;
            OPC_LOAD, OPC_STORE:                                op_to_class = DC_LS;
            OPC_BRANCH, OPC_JAL, OPC_JALR:                      op_to_class = DC_BR;
            default:                                            op_to_class = DC_NONE;
        endcase
    endfunction

endpackage

// File: rtl/dispatch_credit_ctrl_counter.sv
// rs_credit_counter: free-entry credit counter for one reservation station.
// Out-of-range results leave the count untouched and pulse err.
module rs_credit_counter #(
    parameter int CNT_WIDTH   = 4,
    parameter int MAX_CREDITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [1:0]           grant_cnt,
    input  logic                 issue,
    output logic [CNT_WIDTH-1:0] free,
    output logic                 err
);

    localparam logic [CNT_WIDTH-1:0] MAX_C = CNT_WIDTH'(MAX_CREDITS);

    logic [CNT_WIDTH-1:0] free_q, free_d;
    logic [CNT_WIDTH+1:0] sum;

    // Two guard bits: a negative result wraps far above MAX_C, so one compare
    // catches both underflow and overflow.
    always_comb begin
        sum    = {2'b00, free_q} + {{(CNT_WIDTH+1){1'b0}}, issue} - {{CNT_WIDTH{1'b0}}, grant_cnt};
        err    = ~flush & (sum > {2'b00, MAX_C});
        free_d = flush ? MAX_C : err ? free_q : sum[CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) free_q <= MAX_C;
        else      free_q <= free_d;
    end

    assign free = free_q;

endmodule

// File: rtl/dispatch_credit_ctrl.sv
// dispatch_credit_ctrl: in-order 2-wide dispatch grant against per-RS credits,
// remembering a half-dispatched pair so slot 0 is not sent twice.
module dispatch_credit_ctrl
    import dispatch_credit_ctrl_pkg::*;
#(
    parameter int NUM_RS_ENTRIES = 8,
    parameter int CNT_WIDTH      = $clog2(NUM_RS_ENTRIES + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [1:0]           rename_valid,
    input  logic [1:0]           rename_class_0,
    input  logic [1:0]           rename_class_1,
    input  logic                 issue_alu_valid,
    input  logic                 issue_ls_valid,
    input  logic                 issue_branch_valid,
    output logic [1:0]           dispatch_grant,
    output logic                 rename_ready,
    output logic [CNT_WIDTH-1:0] alu_free,
    output logic [CNT_WIDTH-1:0] ls_free,
    output logic [CNT_WIDTH-1:0] br_free,
    output logic                 credit_err
);

    dc_class_e            cls0, cls1;
    logic                 held_q, held_d, credit_err_q, credit_err_d;
    logic                 act, eff_v0, g0, g1;
    logic [CNT_WIDTH-1:0] free0, free1, need1;
    logic [1:0]           alu_gcnt, ls_gcnt, br_gcnt;
    logic [2:0]           cnt_err;

    assign cls0 = dc_class_e'(rename_class_0);
    assign cls1 = dc_class_e'(rename_class_1);

    always_comb begin
        act    = rst & ~flush;
        eff_v0 = rename_valid[0] & ~held_q;
        free0  = (cls0 == DC_ALU) ? alu_free : (cls0 == DC_LS) ? ls_free : br_free;
        free1  = (cls1 == DC_ALU) ? alu_free : (cls1 == DC_LS) ? ls_free : br_free;
        g0     = act & eff_v0 & ((cls0 == DC_NONE) | (free0 != '0));
        // A same-cycle slot-0 grant to the same class already claims one credit.
        need1  = (g0 & (cls0 == cls1)) ? CNT_WIDTH'(2) : CNT_WIDTH'(1);
        g1     = act & rename_valid[1] & (g0 | ~eff_v0) & ((cls1 == DC_NONE) | (free1 >= need1));
        rename_ready   = act & (~rename_valid[0] | g0 | held_q) & (~rename_valid[1] | g1);
        dispatch_grant = {g1, g0};
        held_d   = flush ? 1'b0 : held_q ? ~g1 : (g0 & ~g1 & rename_valid[1]);
        alu_gcnt = {1'b0, g0 & (cls0 == DC_ALU)} + {1'b0, g1 & (cls1 == DC_ALU)};
        ls_gcnt  = {1'b0, g0 & (cls0 == DC_LS)}  + {1'b0, g1 & (cls1 == DC_LS)};
        br_gcnt  = {1'b0, g0 & (cls0 == DC_BR)}  + {1'b0, g1 & (cls1 == DC_BR)};
        credit_err_d = credit_err_q | (|cnt_err);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            held_q       <= 1'b0;
            credit_err_q <= 1'b0;
        end else begin
            held_q       <= held_d;
            credit_err_q <= credit_err_d;
        end
    end

    assign credit_err = credit_err_q;

    rs_credit_counter #(.CNT_WIDTH(CNT_WIDTH), .MAX_CREDITS(NUM_RS_ENTRIES)) u_alu_cnt (
        .clk(clk), .rst(rst), .flush(flush), .grant_cnt(alu_gcnt),
        .issue(issue_alu_valid), .free(alu_free), .err(cnt_err[0])
    );

    rs_credit_counter #(.CNT_WIDTH(CNT_WIDTH), .MAX_CREDITS(NUM_RS_ENTRIES)) u_ls_cnt (
        .clk(clk), .rst(rst), .flush(flush), .grant_cnt(ls_gcnt),
        .issue(issue_ls_valid), .free(ls_free), .err(cnt_err[1])
    );

    rs_credit_counter #(.CNT_WIDTH(CNT_WIDTH), .MAX_CREDITS(NUM_RS_ENTRIES)) u_br_cnt (
        .clk(clk), .rst(rst), .flush(flush), .grant_cnt(br_gcnt),
        .issue(issue_branch_valid), .free(br_free), .err(cnt_err[2])
    );

endmodule

// File: tb/tb_dispatch_credit_ctrl.sv
// tb_dispatch_credit_ctrl: directed vector table, reset-mid-pair sequence and
// randomized traffic against a credit-reservation reference model.
module tb_dispatch_credit_ctrl;
    import dispatch_credit_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic [1:0] rename_valid = 2'b00;
    logic [1:0] rename_class_0 = 2'd0;
    logic [1:0] rename_class_1 = 2'd0;
    logic       issue_alu_valid = 1'b0;
    logic       issue_ls_valid = 1'b0;
    logic       issue_branch_valid = 1'b0;
    logic [1:0] dispatch_grant;
    logic       rename_ready;
    logic [3:0] alu_free, ls_free, br_free;
    logic       credit_err;

    dispatch_credit_ctrl #(.NUM_RS_ENTRIES(8)) dut (
        .clk(clk), .rst(rst), .flush(flush), .rename_valid(rename_valid),
        .rename_class_0(rename_class_0), .rename_class_1(rename_class_1),
        .issue_alu_valid(issue_alu_valid), .issue_ls_valid(issue_ls_valid),
        .issue_branch_valid(issue_branch_valid), .dispatch_grant(dispatch_grant),
        .rename_ready(rename_ready), .alu_free(alu_free), .ls_free(ls_free),
        .br_free(br_free), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] rv, c0, c1;
        logic       ia, il, ib, fl;
        int         g, rdy, alu, ls, br, err;
    } vec_t;

    vec_t tbl[$];
    int n_vec = 0;
    int n_bad = 0;

    int   m_free[3];
    logic m_held, m_err;

    function automatic vec_t v(input logic [1:0] rv, c0, c1, input logic ia, il, ib, fl,
                               input int g, rdy, alu, ls, br, err);
        vec_t r;
        r.rv = rv; r.c0 = c0; r.c1 = c1; r.ia = ia; r.il = il; r.ib = ib; r.fl = fl;
        r.g = g; r.rdy = rdy; r.alu = alu; r.ls = ls; r.br = br; r.err = err;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] rv, c0, c1, input logic ia, il, ib, fl);
        rename_valid = rv; rename_class_0 = c0; rename_class_1 = c1;
        issue_alu_valid = ia; issue_ls_valid = il; issue_branch_valid = ib; flush = fl;
    endtask

    // Reference: slots reserve credits from a scratch copy in program order.
    function automatic void m_eval(input logic [1:0] rv, c0, c1, input logic fl,
                                   output logic [1:0] g, output logic rdy);
        int   tmp[3];
        logic e0;
        tmp = m_free;
        g   = 2'b00;
        e0  = rv[0] && !m_held;
        if (!fl && e0 && (c0 == 2'd3 || tmp[c0] > 0)) begin
            g[0] = 1'b1;
            if (c0 != 2'd3) tmp[c0] = tmp[c0] - 1;
        end
        if (!fl && rv[1] && (g[0] || !e0) && (c1 == 2'd3 || tmp[c1] > 0)) g[1] = 1'b1;
        rdy = !fl && (!rv[0] || g[0] || m_held) && (!rv[1] || g[1]);
    endfunction

    function automatic void m_step(input logic [1:0] rv, c0, c1, input logic ia, il, ib, fl,
                                   input logic [1:0] g);
        int iss[3];
        int n;
        iss = '{int'(ia), int'(il), int'(ib)};
        if (fl) begin
            m_free = '{8, 8, 8};
            m_held = 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                n = m_free[k] + iss[k] - int'(g[0] && c0 == 2'(k)) - int'(g[1] && c1 == 2'(k));
                if (n < 0 || n > 8) m_err = 1'b1;
                else m_free[k] = n;
            end
            m_held = m_held ? !g[1] : (g[0] && !g[1] && rv[1]);
        end
    endfunction

    initial begin
        logic [1:0] rv, c0, c1, gm;
        logic       ia, il, ib, fl, rdy_m;

        // ALU=0 LS=1 BR=2 NONE=3
        tbl.push_back(v(3, 0, 1, 0, 0, 0, 0, 3, 1, 8, 8, 8, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 8, 0));
        tbl.push_back(v(3, 2, 2, 0, 0, 0, 0, 3, 1, 7, 7, 8, 0));
        tbl.push_back(v(3, 2, 2, 0, 0, 0, 0, 3, 1, 7, 7, 6, 0));
        tbl.push_back(v(3, 2, 2, 0, 0, 0, 0, 3, 1, 7, 7, 4, 0));
        tbl.push_back(v(1, 2, 3, 0, 0, 0, 0, 1, 1, 7, 7, 2, 0));
        tbl.push_back(v(3, 2, 2, 0, 0, 1, 0, 1, 0, 7, 7, 1, 0));
        tbl.push_back(v(3, 2, 2, 0, 0, 0, 0, 2, 1, 7, 7, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0, 0));
        tbl.push_back(v(3, 0, 0, 0, 0, 0, 0, 3, 1, 7, 7, 0, 0));
        tbl.push_back(v(3, 0, 0, 0, 0, 0, 0, 3, 1, 5, 7, 0, 0));
        tbl.push_back(v(3, 0, 0, 0, 0, 0, 0, 3, 1, 3, 7, 0, 0));
        tbl.push_back(v(1, 0, 3, 0, 0, 0, 0, 1, 1, 1, 7, 0, 0));
        tbl.push_back(v(3, 0, 1, 1, 0, 0, 0, 0, 0, 0, 7, 0, 0));
        tbl.push_back(v(3, 0, 1, 0, 0, 0, 0, 3, 1, 1, 7, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 6, 0, 0));
        tbl.push_back(v(1, 0, 3, 1, 0, 0, 0, 1, 1, 1, 6, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 6, 0, 0));
        tbl.push_back(v(1, 1, 3, 1, 0, 0, 0, 1, 1, 2, 6, 0, 0));
        tbl.push_back(v(3, 3, 2, 0, 0, 0, 0, 1, 0, 3, 5, 0, 0));
        tbl.push_back(v(3, 3, 2, 1, 1, 1, 1, 0, 0, 3, 5, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 8, 8, 0));
        tbl.push_back(v(3, 0, 0, 0, 0, 0, 0, 3, 1, 8, 8, 8, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 1, 6, 8, 8, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 1, 7, 8, 8, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 1, 8, 8, 8, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 1, 8, 8, 8, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 8, 8, 1));

        chk("op_load", int'(op_to_class(7'b0000011)), int'(DC_LS));
        chk("op_jalr", int'(op_to_class(7'b1100111)), int'(DC_BR));
        chk("op_lui", int'(op_to_class(7'b0110111)), int'(DC_ALU));
        chk("op_fence", int'(op_to_class(7'b0001111)), int'(DC_NONE));

        // Grants must stay low while held in reset even with a valid pair.
        drive(2'd3, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_grant", int'(dispatch_grant), 0);
        chk("rst_ready", int'(rename_ready), 0);
        chk("rst_alu", int'(alu_free), 8);
        chk("rst_ls", int'(ls_free), 8);
        chk("rst_br", int'(br_free), 8);
        chk("rst_err", int'(credit_err), 0);
        @(posedge clk); #1;
        rst = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].rv, tbl[i].c0, tbl[i].c1, tbl[i].ia, tbl[i].il, tbl[i].ib, tbl[i].fl);
            @(negedge clk);
            chk($sformatf("row%0d_grant", i), int'(dispatch_grant), tbl[i].g);
            chk($sformatf("row%0d_ready", i), int'(rename_ready), tbl[i].rdy);
            chk($sformatf("row%0d_alu", i), int'(alu_free), tbl[i].alu);
            chk($sformatf("row%0d_ls", i), int'(ls_free), tbl[i].ls);
            chk($sformatf("row%0d_br", i), int'(br_free), tbl[i].br);
            chk($sformatf("row%0d_err", i), int'(credit_err), tbl[i].err);
            @(posedge clk); #1;
        end

        // Drain BR credits, park in PARTIAL, then drop reset mid-cycle.
        for (int i = 0; i < 4; i++) begin
            drive(2'd3, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        drive(2'd3, 2'd3, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("part_grant", int'(dispatch_grant), 1);
        chk("part_ready", int'(rename_ready), 0);
        chk("part_br", int'(br_free), 0);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("arst_grant", int'(dispatch_grant), 0);
        chk("arst_ready", int'(rename_ready), 0);
        chk("arst_br", int'(br_free), 8);
        chk("arst_err", int'(credit_err), 0);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("arst_rel_grant", int'(dispatch_grant), 3);
        chk("arst_rel_ready", int'(rename_ready), 1);
        @(posedge clk); #1;

        drive(2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        m_free = '{8, 8, 8};
        m_held = 1'b0;
        m_err  = 1'b0;
        rdy_m  = 1'b1;
        rv = 2'd0; c0 = 2'd0; c1 = 2'd0;
        for (int i = 0; i < 3000; i++) begin
            if (rdy_m) begin
                rv = 2'($urandom_range(0, 3));
                c0 = 2'($urandom_range(0, 3));
                c1 = 2'($urandom_range(0, 3));
            end
            fl = ($urandom_range(0, 39) == 0);
            ia = ($urandom_range(0, 2) == 0) && (m_free[0] < 8 || $urandom_range(0, 19) == 0);
            il = ($urandom_range(0, 2) == 0) && (m_free[1] < 8 || $urandom_range(0, 19) == 0);
            ib = ($urandom_range(0, 2) == 0) && (m_free[2] < 8 || $urandom_range(0, 19) == 0);
            drive(rv, c0, c1, ia, il, ib, fl);
            m_eval(rv, c0, c1, fl, gm, rdy_m);
            @(negedge clk);
            chk("rnd_grant", int'(dispatch_grant), int'(gm));
            chk("rnd_ready", int'(rename_ready), int'(rdy_m));
            chk("rnd_alu", int'(alu_free), m_free[0]);
            chk("rnd_ls", int'(ls_free), m_free[1]);
            chk("rnd_br", int'(br_free), m_free[2]);
            chk("rnd_err", int'(credit_err), int'(m_err));
            @(posedge clk); #1;
            m_step(rv, c0, c1, ia, il, ib, fl, gm);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dispatch_credit_ctrl.md
# dispatch_credit_ctrl

Credit-based dispatch controller that sits between rename and the three reservation stations (ALU, LSU, BRU) behind the 2-wide dispatch stage. It tracks free entries per RS, decides in program order which of the two renamed instructions may dispatch this cycle, and back-pressures rename. It also remembers a partially dispatched pair so the held slot-0 instruction is not dispatched twice.

## Interface
Parameters:
- NUM_RS_ENTRIES, 8, entries per reservation station (all three equal)
- CNT_WIDTH, $clog2(NUM_RS_ENTRIES+1), width of each free-credit counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- flush  in  1  pipeline flush; the RSs empty in the same cycle
- rename_valid  in  2  per-slot valid from rename; bit 0 is the older instruction
- rename_class_0  in  2  slot-0 class: 0 ALU, 1 LS, 2 BR, 3 NONE (no RS needed)
- rename_class_1  in  2  slot-1 class, same encoding
- issue_alu_valid  in  1  ALU RS issued one entry this cycle (frees one credit)
- issue_ls_valid  in  1  LSU RS issued one entry
- issue_branch_valid  in  1  BRU RS issued one entry
- dispatch_grant  out  2  per-slot dispatch enable this cycle; gates dispatch_*_valid_0/1
- rename_ready  out  1  pair fully consumed; rename may advance next edge
- alu_free / ls_free / br_free  out  CNT_WIDTH each  current free-credit counts
- credit_err  out  1  sticky: a credit over- or underflow was attempted

## Operation
- Effective valid: eff_v[0] = rename_valid[0] & ~held; eff_v[1] = rename_valid[1].
- Grant rules, in program order:
  - Slot 0 is granted if eff_v[0], no flush, and its class is NONE or has free >= 1.
  - Slot 1 is granted if rename_valid[1], no flush, and slot 0 is granted or eff_v[0]=0.
  - Slot 1 also needs credit. If both slots target the same class, that class needs free >= 2. Otherwise its own class needs free >= 1. NONE always passes.
- rename_ready = ~flush & (every bit set in rename_valid is either granted this cycle or already held).
- State (1 bit, held), two states:
  - IDLE (held=0): a grant on slot 0 without a grant on slot 1 while rename_valid[1] is set -> PARTIAL.
  - PARTIAL (held=1): slot 1 is granted -> IDLE. Flush -> IDLE. Otherwise stay.
- Credit update per class, next edge: free <= free - grants_to_class + issue_class. The net delta is in {-2..+1}. Class NONE consumes no credit.
- Overflow: issue while free == NUM_RS_ENTRIES (with no same-cycle grant to that class) leaves the counter unchanged and sets credit_err.
- Underflow cannot come from grants by construction. Any computed negative result leaves the counter unchanged and sets credit_err.
- Flush has priority over all other events:
  - all counters load NUM_RS_ENTRIES
  - held clears
  - dispatch_grant = 0 and rename_ready = 0 that cycle
  - issue pulses in the flush cycle are ignored
- credit_err clears only on reset.

## Timing
- Reset values: alu_free = ls_free = br_free = NUM_RS_ENTRIES; held = 0; credit_err = 0; dispatch_grant = 0; rename_ready = 0 while rst is low.
- dispatch_grant and rename_ready are combinational from the inputs and registered state; there is no bypass.
- A credit freed by an issue pulse in cycle N is usable for grants in cycle N+1 and not in N.
- A grant in cycle N lowers the free count seen in cycle N+1.
- Reset asserted mid-pair drops the held state immediately (asynchronous).
- Rename must hold its pair stable while rename_ready = 0.

## Structure
- The shared package carries:
  - a 2-bit class enum (DC_ALU, DC_LS, DC_BR, DC_NONE)
  - a helper function mapping an opcode to the class, using the same grouping as dispatch: OP_IMM/OP/LUI/AUIPC/SYSTEM -> ALU; LOAD/STORE -> LS; BRANCH/JAL/JALR -> BR; else NONE
- One sub-module is natural: rs_credit_counter (CNT_WIDTH, reset/flush load value, grant count 0..2, issue pulse, err output), instantiated three times.
- Top level holds the grant logic and the held flag.

## Test plan
- Reset release, pair ALU+LS, both valid -> grant=11, rename_ready=1; next cycle alu_free=7, ls_free=7.
- Start with br_free=1, pair BR+BR -> grant=01, rename_ready=0, held=1. Next cycle, same pair with issue_branch_valid pulsed in the previous cycle -> grant=10, rename_ready=1, br_free=0, held=0.
- alu_free=0, pair ALU+LS -> grant=00, rename_ready=0; LS is not granted out of order. Pulse issue_alu_valid -> next cycle grant=11.
- alu_free=1, grant ALU on slot 0 with issue_alu_valid in the same cycle -> alu_free stays 1.
- While in PARTIAL with counters at 3/5/0, assert flush with issue pulses -> grant=00 that cycle; next cycle counters 8/8/8, held=0.
- At alu_free=8, pulse issue_alu_valid -> alu_free stays 8, credit_err=1 and stays set until rst goes low.
